y86_exec_cc_stage: RTL and testbench

- Execute-stage back end of the Y86 datapath; consumes the 64-bit ALU result and overflow flag from the adder/ALU.
- Maintains the ZF/SF/OF condition-code register.
- Evaluates the jXX/cmovXX condition.
- Registers the execute→memory pipeline bundle behind a valid/ready handshake, with flush support.

---
 rtl/y86_exec_cc_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_y86_exec_cc_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_exec_cc_stage.sv
// ---------------------------------------------------------------------------
// y86_exec_cc_stage
//
// Execute-stage back end of the Y86 datapath. It takes the ALU result and
// signed-overflow flag for the current instruction and does three things:
//   * keeps the ZF/SF/OF condition-code register, written only by an OPq
//     that is actually accepted into the stage,
//   * evaluates the jXX / cmovXX condition against the CC value held at
//     the start of the cycle,
//   * registers the execute->memory bundle in a one-entry valid/ready
//     register (no skid buffer), with a squash path.
//
// Parameters:
//   W         datapath width; must match the ALU operand width
//   REG_NONE  register ID meaning "no destination"
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid / in_ready   execute-side handshake
//   in_icode, in_ifun     instruction code / function
//   in_alu_out, in_alu_ovf ALU result and signed overflow
//   in_val_a              operand A, forwarded to the memory stage
//   in_dst_e, in_dst_m    destination registers for valE / valM
//   flush                 squash the held and the inbound bundle
//   cc_block              inhibit CC update (exception further down)
//   out_valid / out_ready memory-side handshake
//   out_icode, out_cnd, out_val_e, out_val_a, out_dst_e, out_dst_m
//                         registered bundle
//   e_cnd                 combinational condition of the inbound bundle
//   cc_zf, cc_sf, cc_of   condition-code register
//   stall_cnt             cycles spent with out_valid=1 and out_ready=0
//
// Build option:
//   Y86_EXEC_STALL_CNT_EN  when defined, stall_cnt is a saturating
//                          backpressure counter; otherwise it is tied to 0.
// ---------------------------------------------------------------------------
module y86_exec_cc_stage #(
  parameter int          W        = 64,
  parameter logic [3:0]  REG_NONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_icode,
  input  logic [3:0]   in_ifun,
  input  logic [W-1:0] in_alu_out,
  input  logic         in_alu_ovf,
  input  logic [W-1:0] in_val_a,
  input  logic [3:0]   in_dst_e,
  input  logic [3:0]   in_dst_m,

  input  logic         flush,
  input  logic         cc_block,

  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_icode,
  output logic         out_cnd,
  output logic [W-1:0] out_val_e,
  output logic [W-1:0] out_val_a,
  output logic [3:0]   out_dst_e,
  output logic [3:0]   out_dst_m,

  output logic         e_cnd,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic [31:0]  stall_cnt
);

  localparam logic [3:0] ICODE_NOP  = 4'h1;
  localparam logic [3:0] ICODE_CMOV = 4'h2;
  localparam logic [3:0] ICODE_OPQ  = 4'h6;
  localparam logic [3:0] ICODE_JXX  = 4'h7;

  // Pipeline register state
  logic         valid_q, valid_d;
  logic [3:0]   icode_q, icode_d;
  logic         cnd_q,   cnd_d;
  logic [W-1:0] val_e_q, val_e_d;
  logic [W-1:0] val_a_q, val_a_d;
  logic [3:0]   dst_e_q, dst_e_d;
  logic [3:0]   dst_m_q, dst_m_d;

  // Condition-code state
  logic         zf_q, zf_d;
  logic         sf_q, sf_d;
  logic         of_q, of_d;

  logic         accept;
  logic         cc_write;
  logic         cond;
  logic         sf_xor_of;

  // One-entry register: we can take a new bundle when empty or when the
  // current one is leaving this cycle.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign cc_write = accept && (in_icode == ICODE_OPQ) && !cc_block;

  // Condition uses the CC value as it stands now, so an OPq accepted this
  // very cycle does not affect its own cycle's evaluation; the instruction
  // following it sees the new flags.
  assign sf_xor_of = sf_q ^ of_q;

  always_comb begin
    cond = 1'b0;
    unique case (in_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = sf_xor_of | zf_q;
      4'h2:    cond = sf_xor_of;
      4'h3:    cond = zf_q;
      4'h4:    cond = !zf_q;
      4'h5:    cond = !sf_xor_of;
      4'h6:    cond = !sf_xor_of && !zf_q;
      default: cond = 1'b0;
    endcase
  end

  assign e_cnd = cond;

  // Next state of the bundle register
  always_comb begin
    valid_d = valid_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    val_e_d = val_e_q;
    val_a_d = val_a_q;
    dst_e_d = dst_e_q;
    dst_m_d = dst_m_q;

    if (flush) begin
      // Squash wins over both a held bundle and an inbound one.
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      icode_d = in_icode;
      cnd_d   = ((in_icode == ICODE_CMOV) || (in_icode == ICODE_JXX)) ? cond : 1'b0;
      val_e_d = in_alu_out;
      val_a_d = in_val_a;
      // A cmov whose condition fails must not write its destination.
      dst_e_d = ((in_icode == ICODE_CMOV) && !cond) ? REG_NONE : in_dst_e;
      dst_m_d = in_dst_m;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Next state of the condition codes
  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (cc_write) begin
      zf_d = (in_alu_out == '0);
      sf_d = in_alu_out[W-1];
      of_d = in_alu_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      icode_q <= ICODE_NOP;
      cnd_q   <= 1'b0;
      val_e_q <= '0;
      val_a_q <= '0;
      dst_e_q <= REG_NONE;
      dst_m_q <= REG_NONE;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      val_e_q <= val_e_d;
      val_a_q <= val_a_d;
      dst_e_q <= dst_e_d;
      dst_m_q <= dst_m_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign out_valid = valid_q;
  assign out_icode = icode_q;
  assign out_cnd   = cnd_q;
  assign out_val_e = val_e_q;
  assign out_val_a = val_a_q;
  assign out_dst_e = dst_e_q;
  assign out_dst_m = dst_m_q;
  assign cc_zf     = zf_q;
  assign cc_sf     = sf_q;
  assign cc_of     = of_q;

`ifdef Y86_EXEC_STALL_CNT_EN
  // Backpressure counter: saturating, cleared only by reset, and blind to
  // flush (a squashed-but-stalled cycle still counts).
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_y86_exec_cc_stage.sv
// ---------------------------------------------------------------------------
// tb_y86_exec_cc_stage
//
// Directed-vector bench for y86_exec_cc_stage. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point, well clear of the
// next edge. Every expected value below is worked out by hand from the
// instruction semantics.
// ---------------------------------------------------------------------------
module tb_y86_exec_cc_stage;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_icode;
  logic [3:0]   in_ifun;
  logic [W-1:0] in_alu_out;
  logic         in_alu_ovf;
  logic [W-1:0] in_val_a;
  logic [3:0]   in_dst_e;
  logic [3:0]   in_dst_m;
  logic         flush;
  logic         cc_block;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_icode;
  logic         out_cnd;
  logic [W-1:0] out_val_e;
  logic [W-1:0] out_val_a;
  logic [3:0]   out_dst_e;
  logic [3:0]   out_dst_m;
  logic         e_cnd;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;
  logic [31:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] stall_base;

  y86_exec_cc_stage #(.W(W), .REG_NONE(4'hF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_icode   (in_icode),
    .in_ifun    (in_ifun),
    .in_alu_out (in_alu_out),
    .in_alu_ovf (in_alu_ovf),
    .in_val_a   (in_val_a),
    .in_dst_e   (in_dst_e),
    .in_dst_m   (in_dst_m),
    .flush      (flush),
    .cc_block   (cc_block),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_icode  (out_icode),
    .out_cnd    (out_cnd),
    .out_val_e  (out_val_e),
    .out_val_a  (out_val_a),
    .out_dst_e  (out_dst_e),
    .out_dst_m  (out_dst_m),
    .e_cnd      (e_cnd),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] alu, input logic ovf,
                       input logic [63:0] va, input logic [3:0] de,
                       input logic [3:0] dm);
    in_valid   = 1'b1;
    in_icode   = icode;
    in_ifun    = ifun;
    in_alu_out = alu;
    in_alu_ovf = ovf;
    in_val_a   = va;
    in_dst_e   = de;
    in_dst_m   = dm;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic check_cc(input string tag, input logic zf, input logic sf, input logic of_v);
    check({tag, ".zf"}, {63'd0, cc_zf}, {63'd0, zf});
    check({tag, ".sf"}, {63'd0, cc_sf}, {63'd0, sf});
    check({tag, ".of"}, {63'd0, cc_of}, {63'd0, of_v});
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_icode   = 4'h0;
    in_ifun    = 4'h0;
    in_alu_out = '0;
    in_alu_ovf = 1'b0;
    in_val_a   = '0;
    in_dst_e   = 4'hF;
    in_dst_m   = 4'hF;
    flush      = 1'b0;
    cc_block   = 1'b0;
    out_ready  = 1'b1;

    // Reset state
    step(); step();
    check("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check("rst.out_icode", {60'd0, out_icode}, 64'h1);
    check("rst.out_cnd",   {63'd0, out_cnd},   64'd0);
    check("rst.out_val_e", out_val_e, 64'd0);
    check("rst.out_val_a", out_val_a, 64'd0);
    check("rst.out_dst_e", {60'd0, out_dst_e}, 64'hF);
    check("rst.out_dst_m", {60'd0, out_dst_m}, 64'hF);
    check_cc("rst", 1'b1, 1'b0, 1'b0);
    check("rst.stall_cnt", {32'd0, stall_cnt}, 64'd0);
    rst_n = 1'b1;
    step();

    // 1: OPq result zero
    drive(4'h6, 4'h0, 64'h0, 1'b0, 64'h1234, 4'h3, 4'hF);
    #1;
    check("t1.in_ready", {63'd0, in_ready}, 64'd1);
    step(); idle();
    check_cc("t1", 1'b1, 1'b0, 1'b0);
    check("t1.out_valid", {63'd0, out_valid}, 64'd1);
    check("t1.out_val_e", out_val_e, 64'd0);
    check("t1.out_val_a", out_val_a, 64'h1234);
    check("t1.out_icode", {60'd0, out_icode}, 64'h6);
    check("t1.out_dst_e", {60'd0, out_dst_e}, 64'h3);
    check("t1.out_cnd",   {63'd0, out_cnd},   64'd0);
    step();
    check("t1.drain", {63'd0, out_valid}, 64'd0);

    // 2: OPq min-int with overflow -> SF=1 OF=1 ZF=0; then jl, jle, jge
    drive(4'h6, 4'h0, 64'h8000_0000_0000_0000, 1'b1, 64'h0, 4'h2, 4'hF);
    step();
    check_cc("t2", 1'b0, 1'b1, 1'b1);
    drive(4'h7, 4'h2, 64'h0, 1'b0, 64'h0, 4'hF, 4'hF);
    #1;
    check("t2.e_cnd_l", {63'd0, e_cnd}, 64'd0);
    step();
    check("t2.out_cnd_l", {63'd0, out_cnd}, 64'd0);
    check("t2.out_icode", {60'd0, out_icode}, 64'h7);
    drive(4'h7, 4'h1, 64'h0, 1'b0, 64'h0, 4'hF, 4'hF);
    step();
    check("t2.out_cnd_le", {63'd0, out_cnd}, 64'd0);
    drive(4'h7, 4'h5, 64'h0, 1'b0, 64'h0, 4'hF, 4'hF);
    step(); idle();
    check("t2.out_cnd_ge", {63'd0, out_cnd}, 64'd1);
    check_cc("t2.hold", 1'b0, 1'b1, 1'b1);

    // 3: OPq -1 -> ZF=0 SF=1 OF=0; cmove fails, cmovne succeeds
    drive(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0, 4'h1, 4'hF);
    step();
    check_cc("t3", 1'b0, 1'b1, 1'b0);
    drive(4'h2, 4'h3, 64'h55, 1'b0, 64'h55, 4'h3, 4'hF);
    step();
    check("t3.dst_e_cmove", {60'd0, out_dst_e}, 64'hF);
    check("t3.cnd_cmove",   {63'd0, out_cnd},   64'd0);
    drive(4'h2, 4'h4, 64'h55, 1'b0, 64'h55, 4'h3, 4'hF);
    step();
    check("t3.dst_e_cmovne", {60'd0, out_dst_e}, 64'h3);
    check("t3.cnd_cmovne",   {63'd0, out_cnd},   64'd1);
    drive(4'h2, 4'h2, 64'h55, 1'b0, 64'h55, 4'h3, 4'hF);
    #1;
    check("t3.e_cnd_l", {63'd0, e_cnd}, 64'd1);
    in_ifun = 4'h6;
    #1;
    check("t3.e_cnd_g", {63'd0, e_cnd}, 64'd0);
    in_ifun = 4'h9;
    #1;
    check("t3.e_cnd_ifun9", {63'd0, e_cnd}, 64'd0);
    // Non-branch icode with an always-true ifun still registers cnd=0
    drive(4'h3, 4'h0, 64'h77, 1'b0, 64'h0, 4'h2, 4'hF);
    step();
    check("t3.cnd_irmov", {63'd0, out_cnd}, 64'd0);
    check("t3.dst_e_irmov", {60'd0, out_dst_e}, 64'h2);

    // 4: backpressure for 5 cycles with an OPq offered
    out_ready  = 1'b0;
    stall_base = stall_cnt;
    drive(4'h6, 4'h0, 64'h0, 1'b0, 64'h99, 4'h4, 4'hF);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t4.in_ready%0d", i), {63'd0, in_ready}, 64'd0);
      step();
    end
    check("t4.out_valid", {63'd0, out_valid}, 64'd1);
    check("t4.out_icode", {60'd0, out_icode}, 64'h3);
    check("t4.out_val_e", out_val_e, 64'h77);
    check_cc("t4", 1'b0, 1'b1, 1'b0);
`ifdef Y86_EXEC_STALL_CNT_EN
    check("t4.stall_cnt", {32'd0, stall_cnt}, {32'd0, stall_base + 32'd5});
`else
    check("t4.stall_cnt", {32'd0, stall_cnt}, 64'd0);
`endif
    idle();
    out_ready = 1'b1;
    step();
    check("t4.drain", {63'd0, out_valid}, 64'd0);

    // 5: flush alongside an OPq result zero, with a held bundle
    drive(4'h3, 4'h0, 64'h42, 1'b0, 64'h0, 4'h5, 4'hF);
    step();
    check("t5.held", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b0;
    drive(4'h6, 4'h0, 64'h0, 1'b0, 64'h0, 4'h5, 4'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    check("t5.out_valid", {63'd0, out_valid}, 64'd0);
    check("t5.cc_zf", {63'd0, cc_zf}, 64'd0);

    // 6: cc_block OPq result 1 -> CC unchanged, bundle registered
    drive(4'h6, 4'h0, 64'h1, 1'b0, 64'h0, 4'h6, 4'hF);
    cc_block = 1'b1;
    step();
    cc_block = 1'b0;
    idle();
    out_ready = 1'b0;
    check_cc("t6", 1'b0, 1'b1, 1'b0);
    check("t6.out_valid", {63'd0, out_valid}, 64'd1);
    check("t6.out_val_e", out_val_e, 64'h1);
    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6.rst_zf", {63'd0, cc_zf}, 64'd1);
    check("t6.rst_dst_e", {60'd0, out_dst_e}, 64'hF);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Wrap-around: zero result with overflow, then back-to-back je
    drive(4'h6, 4'h0, 64'h0, 1'b1, 64'h0, 4'h1, 4'hF);
    step();
    check_cc("wrap", 1'b1, 1'b0, 1'b1);
    drive(4'h7, 4'h3, 64'h0, 1'b0, 64'h0, 4'hF, 4'hF);
    step(); idle();
    check("wrap.je_cnd", {63'd0, out_cnd}, 64'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
